pr_bus_arbiter: RTL and testbench

- Arbitrates the peripheral bridge bus (word address, write enable, write data, read data) between two masters: the CPU memory stage and a DMA engine.
- The CPU holds default priority with zero-latency combinational pass-through, so its same-cycle load path is preserved.
- The DMA engine gets the bus in idle cycles; a starvation counter forces one DMA beat by stalling the CPU.
- Sits between the CPU's peripheral port and the device decoder (timers at 0x7f00 and 0x7f10).

---
 rtl/pr_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_pr_bus_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pr_bus_arbiter.sv
// Peripheral bus arbiter: the CPU keeps combinational priority and the DMA engine
// uses idle cycles, with a starvation counter that forces a single DMA beat.
module pr_bus_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [29:0] dma_addr,
  input  logic [31:0] dma_wd,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rd,
  output logic [29:0] dev_addr,
  output logic        dev_we,
  output logic [31:0] dev_wd,
  input  logic [31:0] dev_rd
);

  typedef enum logic [1:0] {
    S_NORM  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      dma_rd_q, dma_rd_d;
  logic             contend_s;

  // Grant and bus steering; the CPU path stays purely combinational.
  always_comb begin
    dma_gnt   = dma_req && (!cpu_req || (state_q == S_FORCE));
    cpu_stall = cpu_req && dma_gnt;
    cpu_rd    = dev_rd;
    contend_s = dma_req && cpu_req && !dma_gnt;
    if (dma_gnt) begin
      dev_addr = dma_addr;
      dev_wd   = dma_wd;
      dev_we   = dma_we;
    end else begin
      dev_addr = cpu_addr;
      dev_wd   = cpu_wd;
      dev_we   = cpu_req && cpu_we;
    end
  end

  // Starvation counter, state transitions and DMA read capture.
  always_comb begin
    cnt_d    = cnt_q;
    state_d  = state_q;
    rvalid_d = dma_gnt && !dma_we;
    dma_rd_d = dma_rd_q;

    if (dma_gnt || !dma_req) begin
      cnt_d = '0;
    end else if (contend_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    // A STARVE_MAX of 1 must force on the very next cycle, so NORM may jump to FORCE.
    case (state_q)
      S_NORM: begin
        if (contend_s) begin
          state_d = (cnt_d == CNT_MAX) ? S_FORCE : S_WAIT;
        end else begin
          state_d = S_NORM;
        end
      end
      S_WAIT: begin
        if (dma_gnt || !dma_req) begin
          state_d = S_NORM;
        end else if (cnt_d == CNT_MAX) begin
          state_d = S_FORCE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FORCE: begin
        if (dma_gnt || !dma_req) begin
          state_d = S_NORM;
        end else begin
          state_d = S_FORCE;
        end
      end
      default: state_d = S_NORM;
    endcase

    if (rvalid_d) begin
      dma_rd_d = dev_rd;
    end else begin
      dma_rd_d = dma_rd_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_NORM;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      dma_rd_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      dma_rd_q <= dma_rd_d;
    end
  end

  assign dma_rvalid = rvalid_q;
  assign dma_rd     = dma_rd_q;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Directed self-checking bench for pr_bus_arbiter with STARVE_MAX=4.
module tb_pr_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wd, cpu_rd;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [29:0] dma_addr;
  logic [31:0] dma_wd;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rd;
  logic [29:0] dev_addr;
  logic        dev_we;
  logic [31:0] dev_wd, dev_rd;

  int n_tests = 0;
  int n_fail  = 0;

  pr_bus_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rd(dma_rd),
    .dev_addr(dev_addr), .dev_we(dev_we), .dev_wd(dev_wd), .dev_rd(dev_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // checks are made 2 time units later, well clear of either clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 30'h0; cpu_wd = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 30'h0; dma_wd = 32'h0;
    dev_rd = 32'h0;
    #3;
    chk("rst_rvalid", 32'(dma_rvalid), 32'd0);
    chk("rst_dma_rd", dma_rd, 32'd0);
    chk("rst_gnt", 32'(dma_gnt), 32'd0);
    chk("rst_we", 32'(dev_we), 32'd0);
    tick();
    reset = 1'b1;

    // CPU read and write, no DMA
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h1FC0; dev_rd = 32'h1234_5678;
    #2;
    chk("cpu_rd", cpu_rd, 32'h1234_5678);
    chk("cpu_addr", 32'(dev_addr), 32'h1FC0);
    chk("cpu_rd_we", 32'(dev_we), 32'd0);
    chk("cpu_rd_stall", 32'(cpu_stall), 32'd0);
    chk("cpu_rd_gnt", 32'(dma_gnt), 32'd0);
    tick();
    cpu_we = 1'b1; cpu_wd = 32'h5A5A_0F0F;
    #2;
    chk("cpu_wr_we", 32'(dev_we), 32'd1);
    chk("cpu_wr_wd", dev_wd, 32'h5A5A_0F0F);

    // DMA read with CPU idle
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 30'h1FC4; dev_rd = 32'hCAFE_0001;
    #2;
    chk("dma_rd_gnt", 32'(dma_gnt), 32'd1);
    chk("dma_rd_addr", 32'(dev_addr), 32'h1FC4);
    chk("dma_rd_stall", 32'(cpu_stall), 32'd0);
    tick();
    dma_req = 1'b0; dev_rd = 32'h0;
    #2;
    chk("dma_rvalid1", 32'(dma_rvalid), 32'd1);
    chk("dma_rdata", dma_rd, 32'hCAFE_0001);
    tick();
    #2;
    chk("dma_rvalid0", 32'(dma_rvalid), 32'd0);
    chk("dma_rd_hold", dma_rd, 32'hCAFE_0001);

    // Back-to-back DMA reads with CPU idle
    for (int i = 0; i < 3; i++) begin
      tick();
      dma_req = (i < 2);
      dev_rd  = 32'hB0B0_0000 + 32'(i);
      #2;
      chk($sformatf("b2b_gnt%0d", i), 32'(dma_gnt), (i < 2) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_rv%0d", i), 32'(dma_rvalid), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk($sformatf("b2b_rd%0d", i), dma_rd, 32'hB0B0_0000 + 32'(i - 1));
    end
    tick();
    dma_req = 1'b0;

    // Sustained contention: forced beats at cycles 4 and 9
    for (int i = 0; i < 11; i++) begin
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h1FC0;
      dma_req = (i < 10); dma_we = 1'b0; dma_addr = 30'h1FC4;
      dev_rd  = 32'h0000_1000 + 32'(i);
      #2;
      chk($sformatf("cont_gnt%0d", i), 32'(dma_gnt), (i == 4 || i == 9) ? 32'd1 : 32'd0);
      chk($sformatf("cont_stall%0d", i), 32'(cpu_stall), (i == 4 || i == 9) ? 32'd1 : 32'd0);
      chk($sformatf("cont_addr%0d", i), 32'(dev_addr), (i == 4 || i == 9) ? 32'h1FC4 : 32'h1FC0);
      chk($sformatf("cont_rv%0d", i), 32'(dma_rvalid), (i == 5 || i == 10) ? 32'd1 : 32'd0);
    end
    chk("cont_rdata", dma_rd, 32'h0000_1009);
    tick();
    cpu_req = 1'b0;

    // DMA write under forced grant against a pending CPU write
    for (int i = 0; i < 7; i++) begin
      tick();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 30'h1FC4; cpu_wd = 32'hAAAA_5555;
      dma_req = (i < 5); dma_we = 1'b1; dma_addr = 30'h1FC0; dma_wd = 32'h0000_000B;
      #2;
      chk($sformatf("wr_gnt%0d", i), 32'(dma_gnt), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("wr_we%0d", i), 32'(dev_we), 32'd1);
      chk($sformatf("wr_wd%0d", i), dev_wd, (i == 4) ? 32'h0000_000B : 32'hAAAA_5555);
      chk($sformatf("wr_rv%0d", i), 32'(dma_rvalid), 32'd0);
    end

    // Request drop restarts the starvation count
    for (int i = 0; i < 9; i++) begin
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0;
      dma_req = (i != 2) && (i < 8); dma_we = 1'b1;
      #2;
      chk($sformatf("drop_gnt%0d", i), 32'(dma_gnt), (i == 7) ? 32'd1 : 32'd0);
    end

    // Reset while in the forced state
    for (int i = 0; i < 5; i++) begin
      tick();
      cpu_req = 1'b1; dma_req = 1'b1; dma_we = 1'b0;
      #2;
      chk($sformatf("rf_gnt%0d", i), 32'(dma_gnt), (i == 4) ? 32'd1 : 32'd0);
    end
    #1;
    reset = 1'b0;
    #1;
    chk("rf_gnt_rst", 32'(dma_gnt), 32'd0);
    chk("rf_stall_rst", 32'(cpu_stall), 32'd0);
    chk("rf_rv_rst", 32'(dma_rvalid), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk($sformatf("rf_post_gnt%0d", i), 32'(dma_gnt), (i == 4) ? 32'd1 : 32'd0);
      tick();
    end

    // Reset during a pending read response
    cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dev_rd = 32'h7777_8888;
    tick();
    dma_req = 1'b0;
    #2;
    chk("rr_rvalid", 32'(dma_rvalid), 32'd1);
    chk("rr_rdata", dma_rd, 32'h7777_8888);
    reset = 1'b0;
    #1;
    chk("rr_rvalid_rst", 32'(dma_rvalid), 32'd0);
    chk("rr_rdata_rst", dma_rd, 32'd0);
    tick();
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
